// File: rtl/conv3x3_sram_sched.sv
// 3x3 convolution sequencer over a DIMxDIM image in dual-port SRAM, two taps per cycle, scaled/saturated results.
// 7 cycles per pixel (5 read, drain, write); no backpressure, start ignored while a frame runs.
module conv3x3_sram_sched #(
  parameter int SHIFT = 4,
  parameter int DIM   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [71:0] kernel,
  output logic        busy,
  output logic        done,
  output logic        ena,
  output logic        enb,
  output logic        wena,
  output logic        wenb,
  output logic [15:0] addra,
  output logic [15:0] addrb,
  input  logic [7:0]  qa,
  input  logic [7:0]  qb,
  output logic        res_we,
  output logic [15:0] res_addr,
  output logic [7:0]  res_data
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  localparam logic [7:0] LAST = 8'(DIM - 1);

  state_t             state;
  logic [2:0]         k, nk, pk;
  logic [7:0]         x, y, px, py;
  logic [71:0]        kern;
  logic [127:0]       kx;
  logic               va, vb;
  logic [16:0]        tap_a, tap_b;
  logic signed [7:0]  coef_a, coef_b;
  logic signed [16:0] prod_a, prod_b;
  logic signed [20:0] acc, acc_sum, shifted;
  logic [7:0]         sat;

  assign wena = 1'b1;
  assign wenb = 1'b1;
  assign kx   = {56'd0, kern};

  // {in_range, {y, x}} of tap t around (cx, cy); out-of-range taps become zero padding
  function automatic logic [16:0] tap_addr(input logic [3:0] t, input logic [7:0] cx,
                                           input logic [7:0] cy);
    int tx, ty;
    ty = int'(cy) + int'(t) / 3 - 1;
    tx = int'(cx) + int'(t) % 3 - 1;
    if (ty < 0 || ty >= DIM || tx < 0 || tx >= DIM) return 17'd0;
    return {1'b1, ty[7:0], tx[7:0]};
  endfunction

  // addresses are registered, so they are formed from the pixel/sub-index of the next cycle
  always_comb begin
    px = x;
    py = y;
    if (state == IDLE) begin
      px = 8'd0;
      py = 8'd0;
    end else if (state == WRITE) begin
      if (x == LAST) begin
        px = 8'd0;
        py = y + 8'd1;
      end else begin
        px = x + 8'd1;
      end
    end
    nk    = (state == READ) ? k + 3'd1 : 3'd0;
    tap_a = tap_addr({nk, 1'b0}, px, py);
    tap_b = (nk == 3'd4) ? 17'd0 : tap_addr({nk, 1'b1}, px, py);
  end

  // data on qa/qb belongs to the pair issued one cycle earlier
  always_comb begin
    pk      = (state == DRAIN) ? 3'd4 : ((k == 3'd0) ? 3'd0 : k - 3'd1);
    coef_a  = $signed(kx[{pk, 4'b0} +: 8]);
    coef_b  = (pk == 3'd4) ? 8'sd0 : $signed(kx[{pk, 4'b1000} +: 8]);
    prod_a  = va ? $signed({1'b0, qa}) * coef_a : 17'sd0;
    prod_b  = vb ? $signed({1'b0, qb}) * coef_b : 17'sd0;
    acc_sum = acc + 21'(prod_a) + 21'(prod_b);
    shifted = acc_sum >>> SHIFT;
    if (shifted < 21'sd0)        sat = 8'd0;
    else if (shifted > 21'sd255) sat = 8'd255;
    else                         sat = shifted[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= 3'd0;
      x        <= 8'd0;
      y        <= 8'd0;
      kern     <= 72'd0;
      acc      <= 21'sd0;
      va       <= 1'b0;
      vb       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ena      <= 1'b0;
      enb      <= 1'b0;
      addra    <= 16'd0;
      addrb    <= 16'd0;
      res_we   <= 1'b0;
      res_addr <= 16'd0;
      res_data <= 8'd0;
    end else begin
      va     <= ena;
      vb     <= enb;
      ena    <= 1'b0;
      enb    <= 1'b0;
      res_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kern  <= kernel;
            x     <= 8'd0;
            y     <= 8'd0;
            acc   <= 21'sd0;
            busy  <= 1'b1;
            k     <= 3'd0;
            state <= READ;
            ena   <= tap_a[16];
            enb   <= tap_b[16];
            addra <= tap_a[15:0];
            addrb <= tap_b[15:0];
          end
        end
        READ: begin
          if (k != 3'd0) acc <= acc_sum;
          if (k == 3'd4) begin
            state <= DRAIN;
          end else begin
            k     <= nk;
            ena   <= tap_a[16];
            enb   <= tap_b[16];
            addra <= tap_a[15:0];
            addrb <= tap_b[15:0];
          end
        end
        DRAIN: begin
          res_we   <= 1'b1;
          res_addr <= {y, x};
          res_data <= sat;
          state    <= WRITE;
        end
        WRITE: begin
          acc <= 21'sd0;
          x   <= px;
          y   <= py;
          if (x == LAST && y == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            k     <= 3'd0;
            state <= READ;
            ena   <= tap_a[16];
            enb   <= tap_b[16];
            addra <= tap_a[15:0];
            addrb <= tap_b[15:0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_sram_sched.sv
// Directed bench for conv3x3_sram_sched on a 16x16 image (SHIFT=4): timing, padding, saturation, restart and reset.
module tb_conv3x3_sram_sched;

  localparam int DIM   = 16;
  localparam int NPIX  = DIM * DIM;
  localparam int FRAME = 7 * NPIX;

  localparam logic [71:0] K_IDENT = 72'h00_00_00_00_10_00_00_00_00;
  localparam logic [71:0] K_ALL16 = {9{8'h10}};
  localparam logic [71:0] K_ALL1  = {9{8'h01}};
  localparam logic [71:0] K_NEG16 = {9{8'hF0}};
  localparam logic [71:0] K_MIX   = 72'h05_FD_10_E0_30_08_FF_12_F4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [71:0] kernel = 72'd0;
  logic        busy, done, ena, enb, wena, wenb, res_we;
  logic [15:0] addra, addrb, res_addr;
  logic [7:0]  qa = 8'd0;
  logic [7:0]  qb = 8'd0;
  logic [7:0]  res_data;

  logic [7:0] mem     [0:65535];
  logic [7:0] res_mem [0:65535];

  int total = 0;
  int bad   = 0;
  int writes = 0, dones = 0, wen_bad = 0, sched_bad = 0, order_bad = 0;
  logic [15:0] last_addr = 16'd0;
  time t0 = 0;
  bit  active = 1'b0;

  int fw_n, fw_addr, done_n, busy_start, busy_done, done_next;
  int w0, d0;

  always #5 clk = ~clk;

  conv3x3_sram_sched #(.SHIFT(4), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel(kernel),
    .busy(busy), .done(done), .ena(ena), .enb(enb), .wena(wena), .wenb(wenb),
    .addra(addra), .addrb(addrb), .qa(qa), .qb(qb),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  always @(posedge clk) begin
    if (ena) qa <= mem[addra];
    if (enb) qb <= mem[addrb];
  end

  function automatic logic [15:0] next_addr(input logic [15:0] a);
    logic [7:0] nx, ny;
    nx = a[7:0];
    ny = a[15:8];
    if (int'(nx) == DIM - 1) begin
      nx = 8'd0;
      ny = (int'(ny) == DIM - 1) ? 8'd0 : ny + 8'd1;
    end else begin
      nx = nx + 8'd1;
    end
    return {ny, nx};
  endfunction

  // write log, raster order, and per-phase port activity relative to the accepted start
  always @(negedge clk) begin
    int rel;
    if (wena !== 1'b1 || wenb !== 1'b1) wen_bad++;
    if (done) dones++;
    if (res_we) begin
      res_mem[res_addr] = res_data;
      if (res_addr != 16'd0 && res_addr != next_addr(last_addr)) order_bad++;
      last_addr = res_addr;
      writes++;
    end
    if (active && busy) begin
      rel = int'(($time - t0) / 10) % 7;
      if (rel == 4 && enb !== 1'b0) sched_bad++;
      if (rel >= 5 && (ena !== 1'b0 || enb !== 1'b0)) sched_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".ena"}, 32'(ena), 0);
    chk({tag, ".enb"}, 32'(enb), 0);
    chk({tag, ".wena"}, 32'(wena), 1);
    chk({tag, ".wenb"}, 32'(wenb), 1);
    chk({tag, ".addra"}, 32'(addra), 0);
    chk({tag, ".addrb"}, 32'(addrb), 0);
    chk({tag, ".res_we"}, 32'(res_we), 0);
    chk({tag, ".res_addr"}, 32'(res_addr), 0);
    chk({tag, ".res_data"}, 32'(res_data), 0);
  endtask

  task automatic fill_rand();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++)
        mem[y * 256 + x] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++)
        mem[y * 256 + x] = v;
  endtask

  function automatic int ref_px(input int x, input int y, input logic [71:0] kv);
    int sum, s, yy, xx;
    sum = 0;
    for (int t = 0; t < 9; t++) begin
      yy = y + t / 3 - 1;
      xx = x + t % 3 - 1;
      if (yy >= 0 && yy < DIM && xx >= 0 && xx < DIM)
        sum += int'(mem[yy * 256 + xx]) * int'($signed(kv[8 * t +: 8]));
    end
    s = sum >>> 4;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic int count_ident();
    int n = 0;
    for (int a = 0; a < 65536; a++)
      if (int'(a[7:0]) < DIM && int'(a[15:8]) < DIM && res_mem[a] !== mem[a]) n++;
    return n;
  endfunction

  function automatic int count_const(input logic [7:0] v);
    int n = 0;
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++)
        if (res_mem[y * 256 + x] !== v) n++;
    return n;
  endfunction

  function automatic int count_ref(input logic [71:0] kv);
    int n = 0;
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++)
        if (int'(res_mem[y * 256 + x]) != ref_px(x, y, kv)) n++;
    return n;
  endfunction

  // start a frame, optionally pulse start again at edge `mid`, and measure timing up to done
  task automatic run_frame(input logic [71:0] kv, input int mid);
    int n;
    w0 = writes;
    d0 = dones;
    @(negedge clk);
    kernel = kv;
    start  = 1'b1;
    @(posedge clk);
    t0     = $time;
    active = 1'b1;
    #1;
    start      = 1'b0;
    kernel     = ~kv;
    busy_start = 32'(busy);
    n       = 0;
    fw_n    = -1;
    fw_addr = -1;
    done_n  = -1;
    busy_done = -1;
    while (n < FRAME + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == mid) begin
        start  = 1'b1;
        kernel = K_NEG16;
      end else begin
        start = 1'b0;
      end
      if (res_we && fw_n < 0) begin
        fw_n    = n;
        fw_addr = 32'(res_addr);
      end
      if (done) begin
        done_n    = n;
        busy_done = 32'(busy);
        break;
      end
    end
    @(posedge clk);
    #1;
    done_next = 32'(done);
  endtask

  initial begin
    #2;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;

    fill_rand();
    run_frame(K_IDENT, -1);
    chk("ident.busy_at_E0", 32'(busy_start), 1);
    chk("ident.first_we_edge", 32'(fw_n), 6);
    chk("ident.first_we_addr", 32'(fw_addr), 0);
    chk("ident.done_edge", 32'(done_n), FRAME);
    chk("ident.busy_at_done", 32'(busy_done), 0);
    chk("ident.done_one_cycle", 32'(done_next), 0);
    chk("ident.writes", 32'(writes - w0), NPIX);
    chk("ident.done_pulses", 32'(dones - d0), 1);
    chk("ident.mismatches", 32'(count_ident()), 0);

    fill_const(8'd10);
    run_frame(K_ALL16, -1);
    chk("pad.corner00", 32'(res_mem[16'h0000]), 40);
    chk("pad.edge05", 32'(res_mem[16'h0005]), 60);
    chk("pad.inner55", 32'(res_mem[16'h0505]), 90);
    chk("pad.cornerFF", 32'(res_mem[16'h0F0F]), 40);
    chk("pad.corner0F", 32'(res_mem[16'h000F]), 40);
    chk("pad.edgeF7", 32'(res_mem[16'h0F07]), 60);

    run_frame(K_ALL1, -1);
    chk("shift.corner", 32'(res_mem[16'h0000]), 2);
    chk("shift.edge", 32'(res_mem[16'h0005]), 3);
    chk("shift.inner", 32'(res_mem[16'h0505]), 5);

    fill_const(8'd255);
    run_frame(K_ALL16, -1);
    chk("sat_hi.mismatches", 32'(count_const(8'd255)), 0);
    run_frame(K_NEG16, -1);
    chk("sat_lo.mismatches", 32'(count_const(8'd0)), 0);

    fill_rand();
    run_frame(K_MIX, -1);
    chk("mix.mismatches", 32'(count_ref(K_MIX)), 0);

    fill_rand();
    run_frame(K_IDENT, 500);
    chk("busy_start.done_edge", 32'(done_n), FRAME);
    chk("busy_start.writes", 32'(writes - w0), NPIX);
    chk("busy_start.done_pulses", 32'(dones - d0), 1);
    chk("busy_start.mismatches", 32'(count_ident()), 0);

    w0 = writes;
    @(negedge clk);
    kernel = K_IDENT;
    start  = 1'b1;
    @(posedge clk);
    t0     = $time;
    active = 1'b1;
    #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && (writes - w0) < 101; i++) begin
      @(negedge clk);
      #1;
    end
    chk("midrst.writes_before", 32'(writes - w0), 101);
    active = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = writes;
    d0 = dones;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst.no_writes", 32'(writes - w0), 0);
    chk("midrst.no_done", 32'(dones - d0), 0);
    chk("midrst.idle", 32'(busy), 0);

    fill_rand();
    run_frame(K_IDENT, -1);
    chk("restart.first_we_edge", 32'(fw_n), 6);
    chk("restart.first_we_addr", 32'(fw_addr), 0);
    chk("restart.done_edge", 32'(done_n), FRAME);
    chk("restart.writes", 32'(writes - w0), NPIX);
    chk("restart.mismatches", 32'(count_ident()), 0);

    chk("mon.wen_high", 32'(wen_bad), 0);
    chk("mon.port_schedule", 32'(sched_bad), 0);
    chk("mon.raster_order", 32'(order_bad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
